// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Desc     : SPI master, modes 0-3, NSS active-low selects, fixed sclk divider.
//            LSB-first ordering is available when SPI_MASTER_LSB_FIRST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int DWIDTH = 8,
  parameter int NSS    = 4,
  parameter int CLKDIV = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cs,
  input  logic                                     wr,
  input  logic                                     rd,
  input  logic [DWIDTH-1:0]                        din,
  output logic [DWIDTH-1:0]                        dout,
  input  logic                                     cpol,
  input  logic                                     cpha,
  input  logic                                     lsb_first,
  input  logic [((NSS > 1) ? $clog2(NSS) : 1)-1:0] ss_sel,
  input  logic                                     miso,
  output logic                                     mosi,
  output logic                                     sclk,
  output logic [NSS-1:0]                           ss_n,
  output logic                                     done,
  output logic                                     busy
);

  localparam int SSW = (NSS > 1) ? $clog2(NSS) : 1;
  localparam int TW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int CW  = $clog2(2 * DWIDTH + 1);
  localparam logic [TW-1:0] c_tmr_last = TW'(CLKDIV - 1);
  localparam logic [CW-1:0] c_tog_last = CW'(2 * DWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_tmr;
  logic [CW-1:0]     r_tog;
  logic [DWIDTH-1:0] r_tx;
  logic [DWIDTH-1:0] r_rx;
  logic [DWIDTH-1:0] r_dout;
  logic              r_cpha;
  logic              r_lsb;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_done;
  logic [NSS-1:0]    r_ss_n;

  logic              w_lsb_in;
  logic              w_start;
  logic              w_tmr_end;
  logic              w_lead;
  logic              w_last;
  logic              w_sample;
  logic              w_shift;
  logic [SSW-1:0]    w_idx;
  logic [NSS-1:0]    w_ss_n_sel;
  logic [DWIDTH-1:0] w_tx_next;
  logic [DWIDTH-1:0] w_rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_lsb_in = lsb_first;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = lsb_first;
  assign w_lsb_in     = 1'b0;
`endif

  assign w_start   = cs & wr & ~rd;
  assign w_tmr_end = (r_tmr == c_tmr_last);
  // r_tog counts completed toggles, so the upcoming toggle is leading when r_tog is even
  assign w_lead    = ~r_tog[0];
  assign w_last    = (r_tog == c_tog_last);
  assign w_sample  = w_lead ^ r_cpha;
  assign w_shift   = r_cpha ? (w_lead & (r_tog != '0)) : (~w_lead & ~w_last);
  assign w_tx_next = r_lsb ? {1'b0, r_tx[DWIDTH-1:1]} : {r_tx[DWIDTH-2:0], 1'b0};
  assign w_rx_next = r_lsb ? {miso, r_rx[DWIDTH-1:1]} : {r_rx[DWIDTH-2:0], miso};

  always_comb begin
    w_idx      = (int'(ss_sel) < NSS) ? ss_sel : '0;
    w_ss_n_sel = '1;
    for (int i = 0; i < NSS; i++) begin
      w_ss_n_sel[i] = (int'(w_idx) != i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_tog   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b1;
      r_ss_n  <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_SETUP;
            r_tmr   <= '0;
            r_tog   <= '0;
            r_tx    <= din;
            r_rx    <= '0;
            r_cpha  <= cpha;
            r_lsb   <= w_lsb_in;
            r_sclk  <= cpol;
            r_mosi  <= w_lsb_in ? din[0] : din[DWIDTH-1];
            r_ss_n  <= w_ss_n_sel;
            r_done  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_tmr_end) begin
            r_tmr   <= '0;
            r_state <= S_XFER;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_XFER: begin
          if (w_tmr_end) begin
            r_tmr  <= '0;
            r_sclk <= ~r_sclk;
            r_tog  <= r_tog + CW'(1);
            if (w_sample) begin
              r_rx <= w_rx_next;
            end
            if (w_shift) begin
              r_tx   <= w_tx_next;
              r_mosi <= r_lsb ? w_tx_next[0] : w_tx_next[DWIDTH-1];
            end
            if (w_last) begin
              r_state <= S_HOLD;
            end
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_HOLD: begin
          if (w_tmr_end) begin
            r_tmr   <= '0;
            r_state <= S_IDLE;
            r_dout  <= r_rx;
            r_ss_n  <= '1;
            r_mosi  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout = r_dout;
  assign mosi = r_mosi;
  assign sclk = r_sclk;
  assign ss_n = r_ss_n;
  assign done = r_done;
  assign busy = ~r_done;

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning transfer word width in bits (legal 2..32).
REQ-002 SHALL have parameter NSS, default 4, meaning number of slave-select lines (legal 1..16).
REQ-003 SHALL have parameter CLKDIV, default 5, meaning sclk half-period in clk cycles (legal 1..255).
REQ-004 SHALL provide ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL provide ports: cs  in  1  block select; wr  in  1  write strobe; rd  in  1  read strobe.
REQ-006 SHALL provide ports: din  in  DWIDTH  transmit word; dout  out  DWIDTH  last received word.
REQ-007 SHALL provide ports: cpol  in  1  clock polarity; cpha  in  1  clock phase; lsb_first  in  1  bit order.
REQ-008 SHALL provide ports: ss_sel  in  $clog2(NSS) (min 1)  target slave index.
REQ-009 SHALL provide ports: miso  in  1; mosi  out  1; sclk  out  1; ss_n  out  NSS  active-low slave selects.
REQ-010 SHALL provide ports: done  out  1  idle/result valid; busy  out  1  transfer active (busy = ~done).

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, XFER, HOLD; all timers count clk cycles.
REQ-012 SHALL accept a start in IDLE only when wr & ~rd & cs; strobes in any other state are ignored with no effect.
REQ-013 SHALL latch din, cpol, cpha, lsb_first, ss_sel on the accepting edge; mid-transfer input changes have no effect.
REQ-014 SHALL treat ss_sel >= NSS as index 0.
REQ-015 SHALL, on accept, go to SETUP: ss_n[ss_sel]=0, sclk = latched cpol, mosi = first data bit; SETUP lasts CLKDIV cycles.
REQ-016 SHALL in XFER toggle sclk every CLKDIV cycles, exactly 2*DWIDTH toggles, then go to HOLD.
REQ-017 SHALL, for cpha=0, sample miso on odd (leading) toggles and present next mosi bit on even (trailing) toggles.
REQ-018 SHALL, for cpha=1, present next mosi bit on leading toggles (first bit already valid since SETUP) and sample miso on trailing toggles.
REQ-019 SHALL shift MSB-first when lsb_first=0 and LSB-first when lsb_first=1, for both mosi and received data.
REQ-020 SHALL keep ss_n asserted and sclk at idle level (cpol) for CLKDIV cycles in HOLD, then go to IDLE.
REQ-021 SHALL, on the HOLD->IDLE edge, load dout with the received word, deassert ss_n, drive mosi=0, set done=1.
REQ-022 SHALL hold dout stable until the next transfer completes; rd has no side effects.
REQ-023 SHALL give accept-to-done latency exactly (2*DWIDTH+2)*CLKDIV cycles.
REQ-024 SHALL accept a new start on the same cycle done rises (back-to-back transfers).

Reset
REQ-025 SHALL, while rst=1, asynchronously force: state IDLE, sclk=0, ss_n=all ones, mosi=0, dout=0, done=1, busy=0, timers cleared.
REQ-026 SHALL, on rst mid-transfer, abort immediately without updating dout; first accept possible on the first clk edge after rst falls.

Configuration
REQ-027 SHALL use macro SPI_MASTER_LSB_FIRST_EN: defined -> lsb_first honoured per REQ-019.
REQ-028 SHALL, with SPI_MASTER_LSB_FIRST_EN undefined, keep port lsb_first present but ignored; always MSB-first.

Verification
REQ-029 SHALL cover: DWIDTH=8, CLKDIV=2, mode 0, din=0xA5, slave loops mosi->miso -> dout=0xA5, done after 36 cycles, ss_n=4'b1110 during transfer.
REQ-030 SHALL cover: mode 3 (cpol=1,cpha=1), din=0x3C, slave returns 0xC3 -> dout=0xC3, sclk idles high before/after.
REQ-031 SHALL cover: lsb_first=1 with macro defined, din=0x01 -> first mosi bit 1; macro undefined -> first mosi bit 0.
REQ-032 SHALL cover: wr pulse mid-transfer with din=0xFF -> ignored, transfer completes with original data, ss_sel unchanged.
REQ-033 SHALL cover: rst asserted at toggle 5 -> ss_n=all ones, sclk=0, done=1, dout keeps previous value 0x00.
REQ-034 SHALL cover: ss_sel=5 with NSS=4 -> ss_n[0] asserted; back-to-back start on done edge -> second transfer starts with zero idle cycles.
